red_iterativa_serial: RTL and testbench
=======================================

RED_ITERATIVA_SERIAL -- requirements
Module: red_iterativa_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand bit count; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a comparison; sampled every edge.
REQ-005 Port: modo  input  1  cell function select: 0 = equality, 1 = magnitude (A >= B).
REQ-006 Port: A  input  WIDTH  operand A; bit 0 is the rightmost cell.
REQ-007 Port: B  input  WIDTH  operand B; bit 0 is the rightmost cell.
REQ-008 Port: busy  output  1  high while bits are being processed (state RUN).
REQ-009 Port: done  output  1  one-cycle pulse when Z is updated.
REQ-010 Port: Z  output  1  final-cell result, Z = !W after the last cell; held until the next result.

Function
REQ-011 The block SHALL evaluate the iterative network bit-serially, right to left, one cell per clock, reusing a single typical cell with a registered W.
REQ-012 FSM states SHALL be IDLE, RUN and FIN. Transitions: IDLE->RUN on start; RUN->FIN on the edge processing bit WIDTH-1; FIN->IDLE unconditionally.
REQ-013 On the start-accept edge the block SHALL:
  - capture A, B and modo into internal registers;
  - set W <= 1 and bit index <= 0.
REQ-014 Each RUN edge SHALL:
  - set W <= cell(W, A[idx], B[idx]);
  - increment idx.
REQ-015 Cell function, modo=0: Wn = W & ~(Ai ^ Bi). Final Z = 1 iff A != B.
REQ-016 Cell function, modo=1: Wn = (Ai & ~Bi) | (~(Ai ^ Bi) & W). Final Z = 1 iff A < B (unsigned).
REQ-017 On the RUN->FIN edge, Z SHALL load !Wn and done SHALL rise. done SHALL be high only during FIN.
REQ-018 Latency SHALL be exactly WIDTH edges from the start-accept edge to the edge that raises done.
REQ-019 start SHALL be accepted only in IDLE. Behaviour outside IDLE:
  - start in RUN or FIN is ignored and is not queued;
  - changes to A, B or modo after acceptance have no effect.
REQ-020 Back-to-back operation: start held high SHALL be re-accepted in the IDLE cycle that follows FIN, giving one result every WIDTH+2 cycles.
REQ-021 The index counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap during RUN; it is terminated by the FIN transition.
REQ-022 busy SHALL be high in RUN and low in IDLE and FIN.

Reset
REQ-023 When rst=1 at an edge, the block SHALL set:
  - state = IDLE, W = 1, idx = 0;
  - Z = 0, done = 0, busy = 0.
  This applies in any state, including mid-RUN, and reset takes priority over start.
REQ-024 An aborted comparison SHALL produce no done pulse and SHALL NOT change Z other than to its reset value.

Structure
REQ-025 Package red_iterativa_pkg SHALL hold:
  - the state typedef (IDLE, RUN, FIN);
  - constants MODO_IGUAL = 1'b0 and MODO_MAYOR = 1'b1.
REQ-026 The cell SHALL be a combinational sub-module celda_tipica_p (inputs W, A, B, modo; output Wn), instantiated once.
REQ-027 All sequential logic SHALL reside in red_iterativa_serial. The final inversion Z = !W SHALL be applied at the FIN-entry register.

Verification (WIDTH=8)
REQ-028 modo=0, A=0x5A, B=0x5A, start for 1 cycle -> busy for 8 cycles; done pulses 8 edges after accept with Z=0.
REQ-029 modo=0, A=0x5A, B=0xDA -> Z=1. Repeat with A=0x01, B=0x00 (differ only in bit 0) -> Z=1.
REQ-030 modo=1 cases:
  - A=0x80, B=0x7F -> Z=0;
  - A=0x7F, B=0x80 -> Z=1;
  - A=B=0x33 -> Z=0.
REQ-031 Reset and restart: assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, Z=0, no done pulse. Then start with modo=1, A=0x00, B=0x01 -> Z=1.
REQ-032 Input isolation and throughput:
  - start pulsed during RUN and during FIN, with A/B changed mid-RUN -> result matches the captured operands and only one done pulse occurs;
  - start held high -> done pulses every 10 cycles.

Source files
------------

// File: rtl/red_iterativa_pkg.sv
// -----------------------------------------------------------------------------
// red_iterativa_pkg
// Shared types and constants for the bit-serial iterative comparator.
//   estado_t   : controller states (IDLE, RUN, FIN)
//   MODO_IGUAL : cell computes equality (Z = 1 when A != B)
//   MODO_MAYOR : cell computes magnitude (Z = 1 when A < B, unsigned)
// -----------------------------------------------------------------------------
package red_iterativa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } estado_t;

    localparam logic MODO_IGUAL = 1'b0;
    localparam logic MODO_MAYOR = 1'b1;

endpackage : red_iterativa_pkg

// File: rtl/celda_tipica_p.sv
// -----------------------------------------------------------------------------
// celda_tipica_p
// Combinational typical cell of the iterative comparison network.
// Ports:
//   W    in  : carry-in from the cell on the right (1 = "so far equal / A>=B")
//   A, B in  : operand bits of this cell
//   modo in  : MODO_IGUAL -> equality chain, MODO_MAYOR -> magnitude chain
//   Wn   out : carry-out towards the cell on the left
// -----------------------------------------------------------------------------
module celda_tipica_p
    import red_iterativa_pkg::*;
(
    input  logic W,
    input  logic A,
    input  logic B,
    input  logic modo,
    output logic Wn
);

    logic iguales;

    assign iguales = ~(A ^ B);

    // Magnitude: a higher bit where A wins decides outright; equal bits pass
    // the verdict of the lower bits through.
    assign Wn = (modo == MODO_MAYOR) ? ((A & ~B) | (iguales & W))
                                     : (W & iguales);

endmodule : celda_tipica_p

// File: rtl/red_iterativa_serial.sv
// -----------------------------------------------------------------------------
// red_iterativa_serial
// Bit-serial evaluation of an iterative comparison network: one typical cell
// is reused once per clock, walking the operands from bit 0 up to bit WIDTH-1
// with the inter-cell signal W held in a register.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request a comparison (accepted only in IDLE)
//   modo     : 0 = equality (Z = A != B), 1 = magnitude (Z = A < B)
//   A, B     : operands, captured on the accept edge
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when Z has just been updated
//   Z        : result, held until the next completed comparison
// -----------------------------------------------------------------------------
module red_iterativa_serial
    import red_iterativa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             modo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Z
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(WIDTH - 1);

    estado_t          estado, estado_n;
    logic [WIDTH-1:0] a_r, b_r;
    logic             modo_r;
    logic             w_r;
    logic [IDX_W-1:0] idx;
    logic             z_r;
    logic             wn;
    logic             ultimo;

    assign ultimo = (idx == IDX_ULTIMO);

    celda_tipica_p u_celda (
        .W    (w_r),
        .A    (a_r[idx]),
        .B    (b_r[idx]),
        .modo (modo_r),
        .Wn   (wn)
    );

    // Next state and status outputs
    always_comb begin
        estado_n = estado;
        busy     = 1'b0;
        done     = 1'b0;
        case (estado)
            IDLE: if (start) estado_n = RUN;
            RUN: begin
                busy = 1'b1;
                if (ultimo) estado_n = FIN;
            end
            FIN: begin
                done     = 1'b1;
                estado_n = IDLE;
            end
            default: estado_n = IDLE;
        endcase
    end

    // Control state, running W, bit index and result
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
            w_r    <= 1'b1;
            idx    <= '0;
            z_r    <= 1'b0;
        end else begin
            estado <= estado_n;
            case (estado)
                IDLE: begin
                    if (start) begin
                        w_r <= 1'b1;
                        idx <= '0;
                    end
                end
                RUN: begin
                    w_r <= wn;
                    // Index stops on the last bit; leaving RUN ends the sweep.
                    if (ultimo) z_r <= ~wn;
                    else        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand capture; only meaningful after an accept, so no reset needed
    always_ff @(posedge clk) begin
        if (estado == IDLE && start && !rst) begin
            a_r    <= A;
            b_r    <= B;
            modo_r <= modo;
        end
    end

    assign Z = z_r;

endmodule : red_iterativa_serial

// File: tb/tb_red_iterativa_serial.sv
// -----------------------------------------------------------------------------
// tb_red_iterativa_serial
// Self-checking bench for red_iterativa_serial with WIDTH = 8.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_red_iterativa_serial;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             modo;
    logic [WIDTH-1:0] A, B;
    logic             busy, done, Z;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    red_iterativa_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .modo  (modo),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string          name;
        logic           modo;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic           exp_z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Pulse start for one cycle with the given operands, then follow the
    // operation to its done pulse. Inputs change on negedge, outputs sampled
    // on negedge.
    task automatic run_op(input string name, input logic m, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic exp_z);
        int e;
        int nbusy;
        @(negedge clk);
        modo  = m;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);          // accept edge has passed
        start = 1'b0;
        e     = 0;
        nbusy = 0;
        while (!done && e < 50) begin
            if (busy) nbusy++;
            @(negedge clk);
            e++;
        end
        check({name, " latency"}, e, WIDTH);
        check({name, " busy cycles"}, nbusy, WIDTH);
        check({name, " Z"}, Z, exp_z);
        check({name, " busy low in FIN"}, busy, 0);
        @(negedge clk);
        check({name, " done one cycle"}, done, 0);
        check({name, " Z held"}, Z, exp_z);
    endtask

    initial begin
        int ndone;
        int t[3];
        int nt;

        vecs[0] = '{"eq 5A/5A",  1'b0, 8'h5A, 8'h5A, 1'b0};
        vecs[1] = '{"eq 5A/DA",  1'b0, 8'h5A, 8'hDA, 1'b1};
        vecs[2] = '{"eq 01/00",  1'b0, 8'h01, 8'h00, 1'b1};
        vecs[3] = '{"eq 80/00",  1'b0, 8'h80, 8'h00, 1'b1};
        vecs[4] = '{"mag 80/7F", 1'b1, 8'h80, 8'h7F, 1'b0};
        vecs[5] = '{"mag 7F/80", 1'b1, 8'h7F, 8'h80, 1'b1};
        vecs[6] = '{"mag 33/33", 1'b1, 8'h33, 8'h33, 1'b0};
        vecs[7] = '{"mag FF/00", 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[8] = '{"mag 00/FF", 1'b1, 8'h00, 8'hFF, 1'b1};
        vecs[9] = '{"mag 02/03", 1'b1, 8'h02, 8'h03, 1'b1};

        rst = 1'b1; start = 1'b1; modo = 1'b0; A = '0; B = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset Z", Z, 0);
        rst = 1'b0; start = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].modo, vecs[i].a, vecs[i].b, vecs[i].exp_z);

        // Reset in the 4th RUN cycle: Z was 1 from the last vector
        @(negedge clk);
        modo = 1'b0; A = 8'h5A; B = 8'hDA; start = 1'b1;
        @(negedge clk);          // RUN cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk); // RUN cycle 4
        check("pre-abort busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort Z", Z, 0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);
        check("abort Z stays", Z, 0);
        run_op("restart mag 00/01", 1'b1, 8'h00, 8'h01, 1'b1);

        // Isolation: operands change and start pulses during RUN and FIN
        @(negedge clk);
        modo = 1'b0; A = 8'h5A; B = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'hA5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        nt = 0;
        while (!done && nt < 50) begin
            @(negedge clk);
            nt++;
        end
        check("iso done seen", done, 1);
        check("iso Z", Z, 0);
        if (done) ndone++;
        start = 1'b1;            // pulse during FIN
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            check("iso busy idle", busy, 0);
            if (done) ndone++;
            @(negedge clk);
        end
        check("iso single done", ndone, 1);

        // Throughput with start held high
        modo = 1'b0; A = 8'h01; B = 8'h00; start = 1'b1;
        nt = 0;
        for (int k = 0; k < 60 && nt < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t[nt] = cyc;
                nt++;
                check("b2b Z", Z, 1);
            end
        end
        check("b2b pulses", nt, 3);
        if (nt == 3) begin
            check("b2b period 1", t[1] - t[0], WIDTH + 2);
            check("b2b period 2", t[2] - t[1], WIDTH + 2);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_red_iterativa_serial
